// File: rtl/mips_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, port
// identifiers and the data word returned on a watchdog abort.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } arb_port_t;

    localparam int ARB_ERR_DATA = 0;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the fetch port, data port and single-port memory signals around mem_arb.
// The master modport is the arbiter side; slave is the core/memory environment.
interface mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              core_stall;
    logic              err;

    modport master (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output core_stall, err
    );

    modport slave (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  core_stall, err
    );

endinterface

// File: rtl/mem_arb_wdog.sv
// Watchdog cycle counter for one outstanding memory access.
// Saturates at TIMEOUT_CYC; TIMEOUT_CYC = 0 keeps expired permanently low.
module mem_arb_wdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic cnt_en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt_en && (cnt != LIMIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (TIMEOUT_CYC != 0) && (cnt == LIMIT);

endmodule

// File: rtl/mem_arb.sv
// Two-port (fetch/data) arbiter in front of a single-port memory with a watchdog.
// Define MEM_ARB_RR_EN for round-robin on collisions; default is data-over-fetch priority.
module mem_arb
    import mips_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic      clk,
    input  logic      reset,
    mem_arb_if.master bus
);

    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ARB_ERR_DATA);

    arb_state_t state;
    arb_state_t state_nxt;

    logic              if_gnt_q;
    logic              if_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic              d_gnt_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              err_q;

    logic if_req_eff;
    logic d_req_eff;
    logic pick_d;
    logic grant_if;
    logic grant_d;
    logic busy;
    logic done;
    logic expired;
    logic timeout;
    logic finish;

    // A port is deaf for the single cycle its completion pulse is visible.
    assign if_req_eff = bus.if_req & ~if_rvalid_q;
    assign d_req_eff  = bus.d_req  & ~d_rvalid_q;

`ifdef MEM_ARB_RR_EN
    arb_port_t last_srv;

    always_comb begin
        pick_d = d_req_eff;
        if (if_req_eff && d_req_eff) begin
            pick_d = (last_srv == PORT_IF);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_srv <= PORT_IF;
        end else if (grant_d) begin
            last_srv <= PORT_D;
        end else if (grant_if) begin
            last_srv <= PORT_IF;
        end
    end
`else
    assign pick_d = d_req_eff;
`endif

    assign grant_d  = (state == IDLE) & pick_d;
    assign grant_if = (state == IDLE) & if_req_eff & ~pick_d;

    assign busy    = (state != IDLE);
    assign done    = busy & bus.mem_ready;
    assign timeout = busy & ~bus.mem_ready & expired;
    assign finish  = done | timeout;

    mem_arb_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (grant_if | grant_d),
        .cnt_en  (busy & ~bus.mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = BUSY_D;
                end else if (grant_if) begin
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (finish) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            if_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_gnt_q     <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            if_gnt_q    <= grant_if;
            d_gnt_q     <= grant_d;
            if_rvalid_q <= finish & (state == BUSY_IF);
            d_rvalid_q  <= finish & (state == BUSY_D);
            err_q       <= timeout;

            if (grant_if || grant_d) begin
                mem_req_q <= 1'b1;
            end else if (finish) begin
                mem_req_q <= 1'b0;
            end

            // Command fields are frozen for the whole access once captured.
            if (grant_d) begin
                mem_we_q    <= bus.d_we;
                mem_addr_q  <= bus.d_addr;
                mem_wdata_q <= bus.d_wdata;
            end else if (grant_if) begin
                mem_we_q    <= 1'b0;
                mem_addr_q  <= bus.if_addr;
                mem_wdata_q <= '0;
            end

            if ((state == BUSY_IF) && finish) begin
                if_rdata_q <= timeout ? ERR_WORD : bus.mem_rdata;
            end
            if ((state == BUSY_D) && finish && (timeout || !mem_we_q)) begin
                d_rdata_q <= timeout ? ERR_WORD : bus.mem_rdata;
            end
        end
    end

    assign bus.if_gnt     = if_gnt_q;
    assign bus.if_rvalid  = if_rvalid_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.d_gnt      = d_gnt_q;
    assign bus.d_rvalid   = d_rvalid_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.err        = err_q;
    assign bus.core_stall = (bus.if_req & ~if_rvalid_q) | (bus.d_req & ~d_rvalid_q);

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: cycle vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_arb;

    localparam int TO = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arb #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        rdy;
        logic [31:0] rdata;
        logic        igt;
        logic        irv;
        logic [31:0] irdata;
        logic        dgt;
        logic        drv;
        logic [31:0] drdata;
        logic        mreq;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        err;
        logic        stall;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: who owns the memory, how long it has waited, who went last.
    logic        e_igt, e_irv, e_dgt, e_drv, e_mreq, e_mwe, e_err;
    logic [31:0] e_idata, e_ddata, e_maddr, e_mwdata;
    int          m_owner;
    int          m_wait;
    bit          m_last_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [31:0] ireq, iaddr, dreq, dwe, daddr, dwdata, rdy, rdata,
                               input logic [31:0] igt, irv, irdata, dgt, drv, drdata,
                               input logic [31:0] mreq, mwe, maddr, mwdata, err, stall);
        vec_t r;
        r.ireq = ireq[0];  r.iaddr = iaddr;  r.dreq = dreq[0];  r.dwe = dwe[0];
        r.daddr = daddr;   r.dwdata = dwdata; r.rdy = rdy[0];   r.rdata = rdata;
        r.igt = igt[0];    r.irv = irv[0];   r.irdata = irdata;
        r.dgt = dgt[0];    r.drv = drv[0];   r.drdata = drdata;
        r.mreq = mreq[0];  r.mwe = mwe[0];   r.maddr = maddr;   r.mwdata = mwdata;
        r.err = err[0];    r.stall = stall[0];
        return r;
    endfunction

    task automatic drive(input logic [31:0] ireq, iaddr, dreq, dwe, daddr, dwdata, rdy, rdata);
        bus.if_req    = ireq[0];
        bus.if_addr   = iaddr;
        bus.d_req     = dreq[0];
        bus.d_we      = dwe[0];
        bus.d_addr    = daddr;
        bus.d_wdata   = dwdata;
        bus.mem_ready = rdy[0];
        bus.mem_rdata = rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid,
                                 bus.mem_req, bus.mem_we, bus.err, bus.core_stall}), 64'(0));
        chk({tag, "_rdata"}, {bus.if_rdata, bus.d_rdata}, 64'(0));
        chk({tag, "_cmd"}, {bus.mem_addr, bus.mem_wdata}, 64'(0));
    endtask

    task automatic model_reset();
        {e_igt, e_irv, e_dgt, e_drv, e_mreq, e_mwe, e_err} = '0;
        e_idata = '0; e_ddata = '0; e_maddr = '0; e_mwdata = '0;
        m_owner = 0; m_wait = 0; m_last_d = 1'b0;
    endtask

    // One clock of the reference: consumes this cycle's inputs, produces next cycle's outputs.
    task automatic model_step();
        bit ie, de;
        ie = bus.if_req && !e_irv;
        de = bus.d_req && !e_drv;
        {e_igt, e_irv, e_dgt, e_drv, e_err} = '0;
        if (m_owner == 0) begin
            if (de && (!ie || !RR || !m_last_d)) begin
                m_owner = 2; m_wait = 0; m_last_d = 1'b1;
                e_dgt = 1'b1; e_mreq = 1'b1;
                e_mwe = bus.d_we; e_maddr = bus.d_addr; e_mwdata = bus.d_wdata;
            end else if (ie) begin
                m_owner = 1; m_wait = 0; m_last_d = 1'b0;
                e_igt = 1'b1; e_mreq = 1'b1;
                e_mwe = 1'b0; e_maddr = bus.if_addr;
            end
        end else if (bus.mem_ready) begin
            if (m_owner == 1) begin
                e_irv = 1'b1; e_idata = bus.mem_rdata;
            end else begin
                e_drv = 1'b1;
                if (!e_mwe) e_ddata = bus.mem_rdata;
            end
            e_mreq = 1'b0; m_owner = 0;
        end else if ((TO != 0) && (m_wait == TO)) begin
            if (m_owner == 1) begin
                e_irv = 1'b1; e_idata = '0;
            end else begin
                e_drv = 1'b1; e_ddata = '0;
            end
            e_err = 1'b1; e_mreq = 1'b0; m_owner = 0;
        end else begin
            m_wait++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_limit: got no finish, required finish before time limit");
        $fatal(1, "time limit");
    end

    initial begin
        int   gcount;
        int   got;
        int   exp_port[3];
        logic [31:0] a_if, a_d;

        do_reset();
        #1;
        chk_all_zero("reset");

        //            ireq iaddr           dreq dwe daddr           dwdata   rdy rdata
        //            igt irv irdata       dgt drv drdata          mreq mwe maddr          mwdata err stall
        tbl.push_back(v(1, 32'h0040_0000, 0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 32'h0040_0000, 0, 0, 0, 0, 0, 0,
                        1, 0, 0, 0, 0, 0, 1, 0, 32'h0040_0000, 0, 0, 1));
        tbl.push_back(v(1, 32'h0040_0000, 0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 1, 0, 32'h0040_0000, 0, 0, 1));
        tbl.push_back(v(1, 32'h0040_0000, 0, 0, 0, 0, 1, 32'h2002_000A,
                        0, 0, 0, 0, 0, 0, 1, 0, 32'h0040_0000, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,
                        0, 1, 32'h2002_000A, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,
                        0, 0, 32'h2002_000A, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 32'h0040_0004, 1, 1, 32'h1001_0000, 32'hA, 0, 0,
                        0, 0, 32'h2002_000A, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 32'h0040_0004, 1, 1, 32'h1001_0000, 32'hA, 0, 0,
                        0, 0, 32'h2002_000A, 1, 0, 0, 1, 1, 32'h1001_0000, 32'hA, 0, 1));
        tbl.push_back(v(1, 32'h0040_0004, 1, 1, 32'h1001_0000, 32'hA, 1, 32'hDEAD_BEEF,
                        0, 0, 32'h2002_000A, 0, 0, 0, 1, 1, 32'h1001_0000, 32'hA, 0, 1));
        tbl.push_back(v(1, 32'h0040_0004, 0, 0, 0, 0, 0, 0,
                        0, 0, 32'h2002_000A, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 32'h0040_0004, 0, 0, 0, 0, 0, 0,
                        1, 0, 32'h2002_000A, 0, 0, 0, 1, 0, 32'h0040_0004, 0, 0, 1));
        tbl.push_back(v(1, 32'h0040_0004, 0, 0, 0, 0, 1, 32'h1234_5678,
                        0, 0, 32'h2002_000A, 0, 0, 0, 1, 0, 32'h0040_0004, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,
                        0, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 32'h1001_0004, 0, 0, 0,
                        0, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 0, 32'h1001_0004, 0, 1, 32'hCAFE_F00D,
                        0, 0, 32'h1234_5678, 1, 0, 0, 1, 0, 32'h1001_0004, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,
                        0, 0, 32'h1234_5678, 0, 1, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h5555_5555,
                        0, 0, 32'h1234_5678, 0, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,
                        0, 0, 32'h1234_5678, 0, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(32'(tbl[i].ireq), tbl[i].iaddr, 32'(tbl[i].dreq), 32'(tbl[i].dwe),
                  tbl[i].daddr, tbl[i].dwdata, 32'(tbl[i].rdy), tbl[i].rdata);
            #1;
            chk($sformatf("vec%0d_ctrl", i),
                64'({bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid, bus.mem_req, bus.err, bus.core_stall}),
                64'({tbl[i].igt, tbl[i].irv, tbl[i].dgt, tbl[i].drv, tbl[i].mreq, tbl[i].err, tbl[i].stall}));
            chk($sformatf("vec%0d_if_rdata", i), 64'(bus.if_rdata), 64'(tbl[i].irdata));
            chk($sformatf("vec%0d_d_rdata", i), 64'(bus.d_rdata), 64'(tbl[i].drdata));
            if (tbl[i].mreq) begin
                chk($sformatf("vec%0d_cmd", i), 64'({bus.mem_we, bus.mem_addr}), 64'({tbl[i].mwe, tbl[i].maddr}));
                if (tbl[i].mwe) chk($sformatf("vec%0d_wdata", i), 64'(bus.mem_wdata), 64'(tbl[i].mwdata));
            end
        end

        // Watchdog abort of a data read while d_rdata still holds an earlier value.
        @(negedge clk);
        drive(0, 0, 1, 0, 32'h1001_0010, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("wdog%0d_d_gnt", k), 64'(bus.d_gnt), 64'(k == 1));
            chk($sformatf("wdog%0d_mem_req", k), 64'(bus.mem_req), 64'(k <= 5));
            chk($sformatf("wdog%0d_rvalid_err", k), 64'({bus.d_rvalid, bus.err}), 64'({k == 6, k == 6}));
            chk($sformatf("wdog%0d_stall", k), 64'(bus.core_stall), 64'(k != 6));
            if (k == 6) begin
                chk("wdog_d_rdata", 64'(bus.d_rdata), 64'(0));
                bus.d_req = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        chk("wdog_after", 64'({bus.mem_req, bus.err, bus.d_rvalid, bus.core_stall}), 64'(0));

        // Held fetch request with an always-ready memory.
        @(negedge clk);
        drive(1, 32'h0040_0100, 0, 0, 0, 0, 1, 32'h0000_0011);
        gcount = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("held%0d_if_gnt", k), 64'(bus.if_gnt), 64'(k % 3 == 1));
            chk($sformatf("held%0d_if_rvalid", k), 64'(bus.if_rvalid), 64'(k % 3 == 2));
            if (bus.if_gnt) gcount++;
            if (k == 8) bus.if_req = 1'b0;
        end
        chk("held_grant_count", 64'(gcount), 64'(3));
        bus.mem_ready = 1'b0;

        // Reset in the cycle after the grant, with a completion pending in that cycle.
        @(negedge clk);
        drive(0, 0, 1, 0, 32'h1001_0008, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("rst_mid_d_gnt", 64'(bus.d_gnt), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1, 32'h0000_0077);
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        #1;
        chk("rst_mid_quiet", 64'({bus.d_rvalid, bus.err, bus.mem_req}), 64'(0));

        // Three fresh collisions from reset; the loser withdraws after each grant.
        do_reset();
        exp_port[0] = 1;
        exp_port[1] = RR ? 0 : 1;
        exp_port[2] = 1;
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            drive(1, 32'h0040_0200, 1, 0, 32'h1001_0200, 0, 1, 32'h0000_0100);
            @(negedge clk);
            #1;
            got = bus.d_gnt ? 1 : (bus.if_gnt ? 0 : 2);
            chk($sformatf("coll%0d_winner", p), 64'(got), 64'(exp_port[p]));
            bus.if_req = 1'b0;
            bus.d_req  = 1'b0;
            repeat (2) @(negedge clk);
        end
        bus.mem_ready = 1'b0;

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000 && n_fail < 20; cyc++) begin
            @(negedge clk);
            chk($sformatf("rnd%0d_ctrl", cyc),
                64'({bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid, bus.mem_req, bus.err}),
                64'({e_igt, e_irv, e_dgt, e_drv, e_mreq, e_err}));
            chk($sformatf("rnd%0d_rdata", cyc), {bus.if_rdata, bus.d_rdata}, {e_idata, e_ddata});
            if (e_mreq) begin
                chk($sformatf("rnd%0d_cmd", cyc), 64'({bus.mem_we, bus.mem_addr}), 64'({e_mwe, e_maddr}));
                if (e_mwe) chk($sformatf("rnd%0d_wdata", cyc), 64'(bus.mem_wdata), 64'(e_mwdata));
            end
            a_if = $urandom();
            a_d  = $urandom();
            bus.if_req    = ($urandom_range(0, 99) < 60);
            bus.if_addr   = a_if;
            bus.d_req     = ($urandom_range(0, 99) < 50);
            bus.d_we      = ($urandom_range(0, 1) == 1);
            bus.d_addr    = a_d;
            bus.d_wdata   = $urandom();
            bus.mem_ready = ($urandom_range(0, 99) < 40);
            bus.mem_rdata = $urandom();
            #1;
            chk($sformatf("rnd%0d_stall", cyc), 64'(bus.core_stall),
                64'((bus.if_req && !e_irv) || (bus.d_req && !e_drv)));
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width.
REQ-002 Parameter DATA_W, default 32, memory data width.
REQ-003 Parameter TIMEOUT_CYC, default 255, watchdog limit in cycles; 0 disables the watchdog.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 if_req  in  1, if_addr  in  ADDR_W  instruction-fetch read request and address.
REQ-007 if_gnt  out  1, if_rvalid  out  1, if_rdata  out  DATA_W  fetch grant pulse, completion pulse, read data.
REQ-008 d_req  in  1, d_we  in  1, d_addr  in  ADDR_W, d_wdata  in  DATA_W  data-port request, write enable, address, write data.
REQ-009 d_gnt  out  1, d_rvalid  out  1, d_rdata  out  DATA_W  data grant pulse, completion pulse (read or write ack), read data.
REQ-010 mem_req  out  1, mem_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W  single-port memory command, held until accepted.
REQ-011 mem_ready  in  1, mem_rdata  in  DATA_W  memory completion and read data, valid in the same cycle.
REQ-012 core_stall  out  1  high while any port has a request that has not yet completed.
REQ-013 err  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-014 FSM states are IDLE, BUSY_IF and BUSY_D.
- IDLE: arbitrate in cycle N.
- BUSY_x: entered at N+1.
REQ-015 On entering BUSY_x:
- mem_req=1 and the matching x_gnt=1 for exactly one cycle.
- mem_addr, mem_we and mem_wdata are registered from the winning port and held stable until completion.
REQ-016 Completion: mem_ready=1 in cycle M while BUSY_x.
- At M+1: x_rvalid=1 for one cycle, x_rdata=mem_rdata captured at M, mem_req=0, state=IDLE.
- Fetch is always a read (mem_we=0).
REQ-017 x_rdata holds its last captured value until the next completion on that port; a data write does not update d_rdata.
REQ-018 In the cycle a port's x_rvalid is high, that port's req is ignored by arbitration; a held req is treated as a new request from the following cycle.
REQ-019 Minimum turnaround is 2 cycles per access; back-to-back accesses issue mem_req at N+1 and at M+2.
REQ-020 Simultaneous if_req and d_req in IDLE: the data port wins by default (fixed priority); the losing request stays pending.
REQ-021 core_stall = (if_req & ~if_rvalid) | (d_req & ~d_rvalid), computed combinationally.
REQ-022 Watchdog:
- The cycle counter clears on entering BUSY_x and increments each cycle mem_ready=0.
- If it reaches TIMEOUT_CYC: mem_req drops next cycle, x_rvalid=1, err=1, x_rdata=0, state=IDLE.
REQ-023 mem_ready arriving while IDLE is ignored.

Reset
REQ-024 When reset is high at a clock edge: state=IDLE, all outputs 0, x_rdata=0, counter=0, round-robin pointer = "fetch last served".
REQ-025 Reset mid-access abandons the access silently: no rvalid, no err, and mem_req is low from the next cycle.

Configuration
REQ-026 Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration on simultaneous requests; the port not served last wins, and the pointer updates at every grant.
- Undefined: fixed data-over-fetch priority, with no pointer register.

Structure
REQ-027 Package mips_pkg holds the arb_state_t enum (IDLE, BUSY_IF, BUSY_D), the arb_port_t enum (PORT_IF, PORT_D) and localparam ARB_ERR_DATA = 0.
REQ-028 One sub-module, mem_arb_wdog, contains the watchdog counter (inputs: clear and count enable; output: expired).

Verification
REQ-029 Single fetch: if_req, if_addr=0x0040_0000, mem_ready 2 cycles after mem_req with rdata=0x2002_000A -> if_gnt at N+1, if_rvalid at N+4, if_rdata=0x2002_000A.
REQ-030 Collision without MEM_ARB_RR_EN: if_req and d_req (we=1, addr=0x1001_0000, wdata=0xA) in the same cycle -> data served first; mem_we=1, mem_wdata=0xA; fetch mem_req issues at M+2.
REQ-031 Collision with MEM_ARB_RR_EN: three consecutive simultaneous pairs, starting from reset -> grant order D, IF, D.
REQ-032 Timeout: TIMEOUT_CYC=4, mem_ready held 0 -> err and d_rvalid pulse together, d_rdata=0, mem_req low afterwards, core_stall falls.
REQ-033 Reset mid-access: reset asserted in the cycle after d_gnt -> no d_rvalid, mem_req=0 next cycle, all outputs 0.
REQ-034 Held request: if_req held high for 3 fetches with mem_ready returned immediately -> 3 distinct if_gnt pulses, each 3 cycles apart, with no duplicate grant in any rvalid cycle.
